mem_responder: RTL

Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready request channel and returns read data or write completion over a valid/ready response channel. Backs a word-organised RAM mapped at BASE_ADDR, with byte-strobe writes, configurable wait states and error responses for unmapped addresses. Sits between the core's data-access initiator and on-chip RAM, replacing a flat memory array with a handshaked interface.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_sram_bank.sv | 43 ++++
 rtl/mem_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and the core's fetch decode.
// Contents:
//   DEFAULT_BASE_ADDR / DEFAULT_DEPTH_WORDS : default RAM window
//   BYTE_LANES                              : byte lanes per 32-bit word
//   state_t                                 : responder FSM states
//   word_offset / offset_in_range           : address-window decode helpers
package mem_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h8000_0000;
  localparam int          DEFAULT_DEPTH_WORDS = 16384;
  localparam int          BYTE_LANES          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte offset into the window; addresses below the base wrap to huge values.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return addr - base;
  endfunction

  // 33-bit compare so a window reaching the top of the address space still works.
  function automatic logic offset_in_range(input logic [31:0] offset,
                                           input int          depth_words);
    logic [32:0] limit;
    limit = 33'(depth_words) << 2;
    return ({1'b0, offset} < limit);
  endfunction

endpackage

// File: rtl/mem_sram_bank.sv
// Synchronous single-port word RAM with per-byte write enables.
// Ports:
//   clock  : rising-edge clock
//   en     : port enable; nothing happens when low
//   we     : 1 = write lanes selected by wstrb, 0 = read into rdata
//   wstrb  : byte-lane write mask, bit n covers wdata[8n+7:8n]
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data; holds its value while not read
module mem_sram_bank
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage is deliberately not reset; rdata only changes on an enabled read
  // so the responder can use it directly as its held response data.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int lane = 0; lane < BYTE_LANES; lane++) begin
          if (wstrb[lane]) begin
            mem[addr][lane*8 +: 8] <= wdata[lane*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Handshaked load/store responder in front of a word-organised on-chip RAM.
// One request is accepted at a time; the response follows after WAIT_STATES
// extra cycles and is held until the initiator takes it.
// Ports:
//   clock, reset_n                 : clock and asynchronous active-low reset
//   req_valid / req_ready          : request handshake
//   req_addr                       : byte address, bits [1:0] ignored
//   req_write, req_wdata, req_wstrb: store flag, data and byte enables
//   rsp_valid / rsp_ready          : response handshake
//   rsp_rdata                      : load data, 0 for stores and errors
//   rsp_error                      : address outside the RAM window
module mem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int         ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t      state;
  state_t      next_state;
  logic [3:0]  wait_cnt;
  logic        req_fire;
  logic [31:0] req_offset;
  logic        req_mapped;
  logic        rsp_load_q;
  logic        rsp_error_q;
  logic [31:0] ram_rdata;

  assign req_offset = word_offset(req_addr, BASE_ADDR);
  assign req_mapped = offset_in_range(req_offset, DEPTH_WORDS);
  assign req_fire   = req_valid & req_ready;

  // The RAM is touched only for mapped requests; unmapped stores are dropped.
  mem_sram_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_bank (
    .clock(clock),
    .en   (req_fire & req_mapped),
    .we   (req_write),
    .wstrb(req_wstrb),
    .addr (req_offset[ADDR_W+1:2]),
    .wdata(req_wdata),
    .rdata(ram_rdata)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and handshake outputs. req_ready is gated by reset_n so the
  // initiator never sees a ready while the block is held in reset.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset_n;
        if (req_valid && reset_n) begin
          next_state = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt <= 4'd1) begin
          next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Wait-state counter: loaded at acceptance, counts down while in WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
    end else if (req_fire) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Response attributes captured at acceptance. Load data itself lives in the
  // RAM read register, which is not disturbed until the next accepted request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_load_q  <= 1'b0;
      rsp_error_q <= 1'b0;
    end else if (req_fire) begin
      rsp_load_q  <= !req_write && req_mapped;
      rsp_error_q <= !req_mapped;
    end
  end

  assign rsp_rdata = rsp_load_q ? ram_rdata : 32'h0;
  assign rsp_error = rsp_error_q;

endmodule
